// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, odd parity, stop.
// Define ODD_PARITY_TX_ERR_INJECT_EN to add inject_err, which flips one frame's parity.
module odd_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [BW-1:0]     baud, baud_n;
    logic [CW-1:0]     bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              par, par_n;
    logic              tx_n, busy_n, done_n;
    logic              accept, bit_end, par_calc;

    assign ready   = (state == IDLE) && !rst;
    assign accept  = valid && ready;
    assign bit_end = (baud == BAUD_LAST);

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    assign par_calc = ~^data_in ^ inject_err;
`else
    assign par_calc = ~^data_in;
`endif

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    shift_n = data_in;
                    par_n   = par_calc;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                baud_n = bit_end ? '0 : baud + 1'b1;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                baud_n = bit_end ? '0 : baud + 1'b1;
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = PARITY;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                baud_n = bit_end ? '0 : baud + 1'b1;
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                baud_n = bit_end ? '0 : baud + 1'b1;
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered, so it is derived from where the FSM is heading
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par     <= par_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Scoreboard bench for odd_parity_serial_tx: accepted words queue expected frames,
// a negedge monitor compares every tx cycle. Honours ODD_PARITY_TX_ERR_INJECT_EN.
module tb_odd_parity_serial_tx;

    localparam int DW    = 4;
    localparam int CPB   = 4;
    localparam int NBITS = DW + 3;
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid = 1'b0;
    logic          inject_err = 1'b0;
    logic          ready, tx, busy, done;

    odd_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .valid     (valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [NBITS-1:0] exp_q[$];
    int               acc_q[$];
    logic [NBITS-1:0] cur;
    int               mon_cyc     = 0;
    bit               mon_active  = 0;
    bit               expect_done = 0;
    logic             rst_q       = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference frame built from the word itself, popcount decides parity
    function automatic logic [NBITS-1:0] ref_frame(input logic [DW-1:0] d, input logic inj);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1 + i] = (d >> i) & 1'b1;
        f[DW + 1] = (($countones(d) % 2) == 0) ^ inj;
        f[DW + 2] = 1'b1;
        return f;
    endfunction

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        logic inj_v;
        cyc++;
        if (rst_q) begin
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ready", ready, !rst);
            mon_active  = 0;
            expect_done = 0;
        end else begin
            if (expect_done) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_ready", ready, !rst);
                expect_done = 0;
            end else if (!mon_active) begin
                chk("idle_done", done, 0);
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_frame", busy, 0);
                        cur = '1;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("start_latency", cyc, acc_q.pop_front() + 1);
                    end
                    mon_active = 1;
                    mon_cyc    = 0;
                end else begin
                    chk("idle_tx", tx, 1);
                    chk("idle_ready", ready, !rst);
                end
            end
            if (mon_active) begin
                chk("tx_bit", tx, cur[mon_cyc / CPB]);
                chk("frame_busy", busy, 1);
                chk("frame_ready", ready, 0);
                mon_cyc++;
                if (mon_cyc == FRAME) begin
                    mon_active  = 0;
                    expect_done = 1;
                end
            end
        end
        if (valid && ready) begin
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
            inj_v = inject_err;
`else
            inj_v = 1'b0;
`endif
            exp_q.push_back(ref_frame(data_in, inj_v));
            acc_q.push_back(cyc);
        end
    end

    task automatic wait_accept();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready && t < 200);
        if (!ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid      = 1'b0;
        data_in    = DW'($urandom);
        inject_err = 1'($urandom);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic inj);
        @(posedge clk);
        #1;
        data_in    = d;
        inject_err = inj;
        valid      = 1'b1;
        wait_accept();
    endtask

    initial begin
        int t;
        valid   = 1'b1;
        data_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_accept();

        send(4'h1, 0);
        send(4'h3, 0);
        send(4'h7, 0);

        send(4'h5, 0);
        send(4'hA, 0);

        send(4'h9, 0);
        repeat (2 * CPB + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(4'h9, 0);

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        send(4'h2, 1);
        send(4'h2, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
            send(DW'($urandom), 1'($urandom));
`else
            send(DW'($urandom), 0);
`endif
        end

        t = 0;
        while ((exp_q.size() != 0 || mon_active || expect_done) && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
- Transmit-side counterpart of the team's odd parity checker.
- Accepts a DATA_W-bit word over a valid/ready handshake, computes its odd parity bit and shifts out a serial frame on a single line.
- Frame order: start, data LSB first, parity, stop.
- Feeds a serial receiver or checker in loopback benches and in the link datapath.

Parameters:
- DATA_W, 4, payload width in bits; legal range 1..16.
- CLKS_PER_BIT, 4, clock cycles each frame bit is held on tx; legal range 1..65535.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  DATA_W  payload word; sampled only on accept.
- valid  input  1  data_in is presented.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Accept rule: accept occurs in a cycle where valid && ready.
  - data_in is latched into a shift register.
  - Parity bit is latched as p = ~^data_in, so that popcount(data) + p is odd.
  - valid while ready=0 is ignored; no queuing.
- ready:
  - Combinational: ready = (state == IDLE) && !rst.
  - Low in every other state and throughout reset.
- Reset, while rst=1 at a clock edge:
  - state=IDLE, tx=1, busy=0, done=0.
  - All counters cleared.
- Reset mid-frame:
  - The frame is abandoned at the next edge and tx returns to 1.
  - No done pulse is issued.
- States:
  - IDLE: tx=1, busy=0. On accept go to START.
  - START: tx=0.
  - DATA: tx = shift_reg[0]; shifts right once per bit period; bit counter runs 0..DATA_W-1.
  - PARITY: tx = p.
  - STOP: tx=1.
- Every non-IDLE state holds for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and then advances state.
- Transitions: START→DATA; DATA→PARITY after DATA_W bits; PARITY→STOP; STOP→IDLE.
- tx, busy and the state register are registered outputs; nothing is combinational to data_in.
- Latency: tx drops to 0 on the first clock edge after the accept edge.
- Frame length: exactly (DATA_W+3)*CLKS_PER_BIT cycles of busy=1.
- done:
  - Registered; high for exactly one cycle, the first cycle back in IDLE.
  - ready=1 in that same cycle.
  - An accept in the done cycle starts the next frame immediately, giving back-to-back frames with no extra idle bit.
- busy is 1 from the cycle after accept through the last STOP cycle.
- Counter widths:
  - Baud counter is $clog2(CLKS_PER_BIT+1) bits.
  - Bit counter is $clog2(DATA_W+1) bits.
  - No wrap beyond terminal counts.
- CLKS_PER_BIT=1: one cycle per bit; behaviour is otherwise identical.
- Changes on data_in after accept do not affect the frame in flight.

Optional Feature:
- Macro: ODD_PARITY_TX_ERR_INJECT_EN.
- When defined:
  - Adds input port inject_err (1 bit), sampled on accept.
  - If inject_err=1 at accept, the latched parity bit is inverted, giving an even-parity frame so that a downstream checker must flag error.
  - Only the frame accepted with inject_err=1 is affected.
- When undefined:
  - The port does not exist.
  - Parity is always odd.

Test Plan:
- Reset: hold rst=1 for 3 cycles with valid=1 -> tx=1, ready=0, busy=0, done=0; after release ready=1.
- Send data_in=4'h0, CLKS_PER_BIT=4 -> tx sequence start 0, data 0,0,0,0, parity 1, stop 1, each bit 4 cycles; busy=1 for 28 cycles; done pulses once.
- Send 4'h1, then 4'h3, then 4'h7, each accepted in the done cycle of the previous frame -> parity bits 0, 1, 0; frames contiguous with no idle gap; data LSB first (4'h3 shows 1,1,0,0).
- Assert valid with 4'hA mid-frame of 4'h5 -> 4'hA ignored, 4'h5 frame unchanged (parity 1); 4'hA is accepted only once ready returns.
- Assert rst during the DATA state of 4'h9 -> tx=1 and busy=0 on the next edge, no done pulse; a subsequent 4'h9 sends a full frame with parity 1.
- With ODD_PARITY_TX_ERR_INJECT_EN, send 4'h2 with inject_err=1 -> parity bit 1 (even frame); the next 4'h2 with inject_err=0 -> parity bit 0.
